// File: rtl/instruction_memory_pipe.sv
// Instruction fetch memory (DEPTH words, word i = i*3) with one registered response slot; IMEM_WRITE_EN adds a write port.
// Latency: an accepted fetch shows on Instruction/Fault/RespValid one cycle later; back-to-back fetches sustain one per cycle.
// Backpressure: ReqReady = !RespValid || RespReady (0 in Reset); a stalled response holds Instruction/Fault stable.
module instruction_memory_pipe #(
    parameter int                    DEPTH      = 128,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Address,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [1:0]            Fault,
`ifdef IMEM_WRITE_EN
    input  logic                  WrEn,
    input  logic [31:0]           WrAddr,
    input  logic [DATA_WIDTH-1:0] WrData,
`endif
    output logic [15:0]           FetchCount
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state;
    logic [AW-1:0]         rd_idx;
    logic                  rd_oor;
    logic                  rd_mis;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  accept;

    assign rd_idx = Address[AW+1:2];
    assign rd_oor = Address[31:2] >= 30'(DEPTH);
    assign rd_mis = |Address[1:0];

`ifdef IMEM_WRITE_EN
    logic [DATA_WIDTH-1:0] mem_words [DEPTH];
    logic [AW-1:0]         wr_idx;
    logic                  wr_oor;
    logic                  wr_unused;

    assign wr_idx    = WrAddr[AW+1:2];
    assign wr_oor    = WrAddr[31:2] >= 30'(DEPTH);
    assign wr_unused = ^WrAddr[1:0];

    // Power-up contents come from the declaration initialiser so Reset never touches the array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q = DATA_WIDTH'(i * 3);

        always_ff @(posedge Clk) begin
            if (WrEn && !wr_oor && (wr_idx == AW'(i))) begin
                word_q <= WrData;
            end
        end

        assign mem_words[i] = word_q;
    end

    // Read samples the pre-write value, giving read-first on a same-word collision.
    assign rd_word = mem_words[rd_idx];
`else
    assign rd_word = DATA_WIDTH'(32'(rd_idx) * 32'd3);
`endif

    assign rd_dat    = rd_oor ? NOP_WORD : rd_word;
    assign RespValid = (state == FULL);
    assign ReqReady  = !Reset && (!RespValid || RespReady);
    assign accept    = ReqValid && ReqReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= EMPTY;
            Instruction <= '0;
            Fault       <= 2'b00;
            FetchCount  <= 16'd0;
        end else begin
            if (accept) begin
                state       <= FULL;
                Instruction <= rd_dat;
                Fault       <= {rd_oor, rd_mis};
                if (FetchCount != 16'hFFFF) begin
                    FetchCount <= FetchCount + 16'd1;
                end
            end else if ((state == FULL) && RespReady) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_pipe.sv
// Directed bench for instruction_memory_pipe; write-port steps build only with IMEM_WRITE_EN.
module tb_instruction_memory_pipe;

    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] Instruction;
    logic        RespValid;
    logic        RespReady;
    logic [1:0]  Fault;
    logic [15:0] FetchCount;
`ifdef IMEM_WRITE_EN
    logic        WrEn;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instruction_memory_pipe #(
        .DEPTH      (128),
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_WORD   (NOP)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Address     (Address),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .Instruction (Instruction),
        .RespValid   (RespValid),
        .RespReady   (RespReady),
        .Fault       (Fault),
`ifdef IMEM_WRITE_EN
        .WrEn        (WrEn),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
`endif
        .FetchCount  (FetchCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Address   = 32'h0;
        ReqValid  = 1'b0;
        RespReady = 1'b0;
`ifdef IMEM_WRITE_EN
        WrEn   = 1'b0;
        WrAddr = 32'h0;
        WrData = 32'h0;
`endif
        tick();
        tick();
        chk("rst_respvalid", 64'(RespValid), 64'd0);
        chk("rst_instr", 64'(Instruction), 64'd0);
        chk("rst_fault", 64'(Fault), 64'd0);
        chk("rst_count", 64'(FetchCount), 64'd0);
        chk("rst_reqready", 64'(ReqReady), 64'd0);

        Reset = 1'b0;
        #1;
        chk("idle_reqready", 64'(ReqReady), 64'd1);

        // single fetch of word 3
        ReqValid  = 1'b1;
        Address   = 32'h0000_000C;
        RespReady = 1'b1;
        tick();
        chk("f0c_valid", 64'(RespValid), 64'd1);
        chk("f0c_instr", 64'(Instruction), 64'd9);
        chk("f0c_fault", 64'(Fault), 64'd0);
        chk("f0c_count", 64'(FetchCount), 64'd1);

        // back-to-back 0x0, 0x4, 0x8
        Address = 32'h0;
        #1;
        chk("b2b_rdy0", 64'(ReqReady), 64'd1);
        tick();
        chk("b2b_instr0", 64'(Instruction), 64'd0);
        Address = 32'h4;
        #1;
        chk("b2b_rdy1", 64'(ReqReady), 64'd1);
        tick();
        chk("b2b_instr1", 64'(Instruction), 64'd3);
        Address = 32'h8;
        #1;
        chk("b2b_rdy2", 64'(ReqReady), 64'd1);
        tick();
        chk("b2b_instr2", 64'(Instruction), 64'd6);
        chk("b2b_valid", 64'(RespValid), 64'd1);
        chk("b2b_count", 64'(FetchCount), 64'd4);

        // stall for three cycles while the address wanders
        RespReady = 1'b0;
        Address   = 32'h14;
        #1;
        chk("stall_rdy", 64'(ReqReady), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            Address = 32'h200 + 32'(k * 4 + 1);
            chk("stall_instr", 64'(Instruction), 64'd6);
            chk("stall_fault", 64'(Fault), 64'd0);
            chk("stall_valid", 64'(RespValid), 64'd1);
            chk("stall_rdy_k", 64'(ReqReady), 64'd0);
        end
        chk("stall_count", 64'(FetchCount), 64'd4);
        RespReady = 1'b1;
        ReqValid  = 1'b0;
        #1;
        chk("drain_rdy", 64'(ReqReady), 64'd1);
        tick();
        chk("drain_valid", 64'(RespValid), 64'd0);
        chk("drain_count", 64'(FetchCount), 64'd4);

        // fault cases
        ReqValid = 1'b1;
        Address  = 32'h0000_0200;
        tick();
        chk("oor_instr", 64'(Instruction), 64'(NOP));
        chk("oor_fault", 64'(Fault), 64'd2);
        Address = 32'h0000_0006;
        tick();
        chk("mis_instr", 64'(Instruction), 64'd3);
        chk("mis_fault", 64'(Fault), 64'd1);
        Address = 32'h0000_0203;
        tick();
        chk("both_instr", 64'(Instruction), 64'(NOP));
        chk("both_fault", 64'(Fault), 64'd3);
        Address = 32'h0000_01FC;
        tick();
        chk("last_instr", 64'(Instruction), 64'd381);
        chk("last_fault", 64'(Fault), 64'd0);
        chk("fault_count", 64'(FetchCount), 64'd8);

        // reset while full discards the response
        RespReady = 1'b0;
        Reset     = 1'b1;
        #1;
        chk("rstfull_rdy", 64'(ReqReady), 64'd0);
        tick();
        chk("rstfull_valid", 64'(RespValid), 64'd0);
        chk("rstfull_count", 64'(FetchCount), 64'd0);
        chk("rstfull_instr", 64'(Instruction), 64'd0);
        Reset     = 1'b0;
        RespReady = 1'b1;
        Address   = 32'h4;
        tick();
        chk("post_rst_instr", 64'(Instruction), 64'd3);
        chk("post_rst_count", 64'(FetchCount), 64'd1);

`ifdef IMEM_WRITE_EN
        // write/read collision is read-first
        Address = 32'h10;
        WrEn    = 1'b1;
        WrAddr  = 32'h10;
        WrData  = 32'hDEAD_BEEF;
        tick();
        chk("wr_old", 64'(Instruction), 64'd12);
        WrEn = 1'b0;
        tick();
        chk("wr_new", 64'(Instruction), 64'hDEAD_BEEF);
        // out-of-range write is dropped; word 0 stays 0
        WrEn   = 1'b1;
        WrAddr = 32'h200;
        WrData = 32'h1234_5678;
        Address = 32'h0;
        tick();
        WrEn = 1'b0;
        tick();
        chk("wr_oor", 64'(Instruction), 64'd0);
`endif

        ReqValid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_memory_pipe.md
INSTRUCTION_MEMORY_PIPE -- requirements
Module: instruction_memory_pipe

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named Clk and Reset.
REQ-002 The module SHALL have these parameters (name, default, meaning):
- DEPTH, 128, number of words; a power of two, at least 2.
- DATA_WIDTH, 32, instruction word width.
- NOP_WORD, 0, word returned on an out-of-range fetch.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1, clock; all state updates on rising edge.
- Reset, in, 1, synchronous active-high reset.
- Address, in, 32, byte address of the fetch.
- ReqValid, in, 1, fetch request valid.
- ReqReady, out, 1, fetch request accepted this cycle.
- Instruction, out, DATA_WIDTH, fetched word.
- RespValid, out, 1, Instruction/Fault valid.
- RespReady, in, 1, consumer takes the response.
- Fault, out, 2, bit0 misaligned, bit1 out of range.
- FetchCount, out, 16, count of accepted fetches, saturating.

Function
REQ-004 Word index SHALL be Address[log2(DEPTH)+1:2]; an address SHALL be out of range when Address[31:2] >= DEPTH.
REQ-005 Word i SHALL initialise to i*3, truncated to DATA_WIDTH.
REQ-006 The output stage SHALL be a two-state machine: EMPTY (RespValid=0) and FULL (RespValid=1).
REQ-007 ReqReady SHALL be combinationally !RespValid || RespReady.
REQ-008 A request SHALL be accepted when ReqValid && ReqReady. Accept latency SHALL be exactly one cycle: RespValid=1 on the next edge with Instruction and Fault registered.
REQ-009 Transitions SHALL be:
- EMPTY->FULL on accept.
- FULL->FULL on accept together with RespReady (back-to-back, one per cycle).
- FULL->EMPTY on RespReady without accept.
- FULL with RespReady=0 SHALL hold.
REQ-010 While FULL and RespReady=0, Instruction and Fault SHALL hold stable regardless of Address and ReqValid.
REQ-011 An out-of-range fetch SHALL return NOP_WORD with Fault[1]=1.
REQ-012 A misaligned fetch (Address[1:0]!=0) SHALL return the word at the truncated index with Fault[0]=1. Both fault bits MAY be set together.
REQ-013 FetchCount SHALL increment by 1 per accepted request and saturate at 16'hFFFF.

Reset
REQ-014 On Reset=1 at a rising edge:
- state SHALL become EMPTY.
- RespValid, Instruction, Fault and FetchCount SHALL become 0.
REQ-015 While Reset=1, ReqReady SHALL be 0, no request SHALL be accepted, and an in-flight response SHALL be discarded.
REQ-016 Reset SHALL NOT alter memory contents.

Configuration
REQ-017 When IMEM_WRITE_EN is defined, the module SHALL add three ports: WrEn (in, 1), WrAddr (in, 32) and WrData (in, DATA_WIDTH).
REQ-018 With IMEM_WRITE_EN defined, the write port SHALL behave as follows:
- WrEn=1 SHALL write WrData to word WrAddr[log2(DEPTH)+1:2] at the rising edge.
- Out-of-range writes SHALL be ignored.
- A write and an accepted fetch to the same word in the same cycle SHALL return the old data (read-first).
- Writes SHALL proceed during Reset.
REQ-019 Without IMEM_WRITE_EN, the memory SHALL be read-only and those ports SHALL not exist.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then ReqValid=1, Address=0x0000000C, RespReady=1 -> next cycle RespValid=1, Instruction=9, Fault=0, FetchCount=1.
- Back-to-back fetches 0x0, 0x4, 0x8 with RespReady=1 -> Instruction 0, 3, 6 on three consecutive cycles, ReqReady held 1.
- FULL with RespReady=0 for 3 cycles while Address changes -> ReqReady=0, Instruction/Fault stable; RespReady=1 -> drain, then EMPTY.
- Address=0x00000200 with DEPTH=128 -> Instruction=NOP_WORD, Fault=2'b10; Address=0x00000006 -> Instruction=3, Fault=2'b01.
- Reset asserted while FULL -> next cycle RespValid=0, FetchCount=0; fetch of 0x4 after reset -> Instruction=3 (memory intact).
- IMEM_WRITE_EN: write 0xDEADBEEF to 0x10 in the same cycle as a fetch of 0x10 -> returns 12. Next fetch of 0x10 -> 0xDEADBEEF.
